pipeline_hazard_ctrl: RTL and testbench

Interlock controller for the 5-stage pipeline (IF/ID/EX/MEM/WB), which has no forwarding.
- Tracks in-flight destination registers in a 3-entry scoreboard mirroring EX/MEM/WB.
- Stalls IF/ID and injects EX bubbles on read-after-write hazards.
- Holds EX for the multi-cycle multiplier and injects MEM bubbles while it does.
- Sits beside the decode stage; drives the enables/flushes of the PC, ID and EX/MEM pipeline registers.

---
 rtl/pipeline_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Interlock controller for a 5-stage pipeline without forwarding: RAW stalls and multiplier holds.
// Latency: hazard/busy to stall/hold outputs is combinational (same cycle); scoreboard advances each edge.
// Backpressure: pc_en/id_en drop on a hazard or busy multiplier; EX gets a bubble on hazard, EX held and MEM bubbled while busy.
module pipeline_hazard_ctrl #(
    parameter int MUL_LAT   = 2,
    parameter int RF_BYPASS = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_a_reg,
    input  logic [4:0]       id_b_reg,
    input  logic             id_uses_a,
    input  logic             id_uses_b,
    input  logic             id_wb_en,
    input  logic [4:0]       id_wb_reg,
    input  logic             id_is_mul,
    output logic             pc_en,
    output logic             id_en,
    output logic             ex_flush,
    output logic             ex_hold,
    output logic             mem_flush,
    output logic [CNT_W-1:0] stall_count
);

    // Scoreboard entries: index 0 = EX, 1 = MEM, 2 = WB
    logic [2:0]      sb_v;
    logic [2:0][4:0] sb_r;
    logic [3:0]      mul_cnt;
    logic [CNT_W-1:0] stall_cnt;

    logic match_a;
    logic match_b;
    logic hazard;
    logic busy;
    logic issue;
    logic stall;

    // Compare ID sources against in-flight destinations; WB is skipped when the RF forwards its write
    always_comb begin
        match_a = 1'b0;
        match_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if ((i < 2) || (RF_BYPASS == 0)) begin
                if (sb_v[i] && (sb_r[i] == id_a_reg)) match_a = 1'b1;
                if (sb_v[i] && (sb_r[i] == id_b_reg)) match_b = 1'b1;
            end
        end
        if (id_a_reg == 5'd0) match_a = 1'b0;
        if (id_b_reg == 5'd0) match_b = 1'b0;
    end

    assign hazard = id_valid & ((id_uses_a & match_a) | (id_uses_b & match_b));
    assign busy   = (mul_cnt != 4'd0);
    assign issue  = id_valid & ~hazard & ~busy;
    assign stall  = hazard | busy;

    // Pipeline control outputs; reset forces the pipe frozen with bubbles in EX and MEM
    always_comb begin
        pc_en     = 1'b0;
        id_en     = 1'b0;
        ex_flush  = 1'b1;
        ex_hold   = 1'b0;
        mem_flush = 1'b1;
        if (rst) begin
            pc_en     = ~stall;
            id_en     = ~stall;
            ex_flush  = ~busy & ~issue;
            ex_hold   = busy;
            mem_flush = busy;
        end
    end

    // Scoreboard shift: while the multiplier is busy EX keeps its entry and MEM receives a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_v <= '0;
            sb_r <= '0;
        end else if (busy) begin
            sb_v[2] <= sb_v[1];
            sb_r[2] <= sb_r[1];
            sb_v[1] <= 1'b0;
            sb_r[1] <= 5'd0;
        end else begin
            sb_v[2] <= sb_v[1];
            sb_r[2] <= sb_r[1];
            sb_v[1] <= sb_v[0];
            sb_r[1] <= sb_r[0];
            if (issue) begin
                sb_v[0] <= id_wb_en & (id_wb_reg != 5'd0);
                sb_r[0] <= id_wb_reg;
            end else begin
                sb_v[0] <= 1'b0;
                sb_r[0] <= 5'd0;
            end
        end
    end

    // Multiplier hold counter: loaded on a multiply issue, counts down to release EX
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_cnt <= 4'd0;
        end else if (busy) begin
            mul_cnt <= mul_cnt - 4'd1;
        end else if (issue && id_is_mul && (MUL_LAT > 1)) begin
            mul_cnt <= 4'(MUL_LAT - 1);
        end
    end

    // Saturating count of cycles in which the PC did not advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign stall_count = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl using two instances (no-bypass/MUL_LAT=4/CNT_W=4 and bypass/MUL_LAT=2).
// Stimulus pushes hand-computed expectations into a queue; a monitor pops and compares at each falling edge.
// Inputs change 1 time unit after the rising edge, so outputs are sampled mid-cycle.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       v;
        logic [4:0] a;
        logic       ua;
        logic [4:0] b;
        logic       ub;
        logic       we;
        logic [4:0] wr;
        logic       mul;
    } in_t;

    typedef struct {
        bit          sel;
        int          id;
        logic        pc;
        logic        exf;
        logic        exh;
        logic        mf;
        logic [15:0] cnt;
    } exp_t;

    in_t in_a;
    in_t in_b;

    logic        pc_a, id_a, exf_a, exh_a, mf_a;
    logic [3:0]  cnt_a;
    logic        pc_b, id_b, exf_b, exh_b, mf_b;
    logic [15:0] cnt_b;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_id  = 0;

    pipeline_hazard_ctrl #(.MUL_LAT(4), .RF_BYPASS(0), .CNT_W(4)) dut_a (
        .clk(clk), .rst(in_a.rst), .id_valid(in_a.v),
        .id_a_reg(in_a.a), .id_b_reg(in_a.b), .id_uses_a(in_a.ua), .id_uses_b(in_a.ub),
        .id_wb_en(in_a.we), .id_wb_reg(in_a.wr), .id_is_mul(in_a.mul),
        .pc_en(pc_a), .id_en(id_a), .ex_flush(exf_a), .ex_hold(exh_a), .mem_flush(mf_a),
        .stall_count(cnt_a)
    );

    pipeline_hazard_ctrl #(.MUL_LAT(2), .RF_BYPASS(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(in_b.rst), .id_valid(in_b.v),
        .id_a_reg(in_b.a), .id_b_reg(in_b.b), .id_uses_a(in_b.ua), .id_uses_b(in_b.ub),
        .id_wb_en(in_b.we), .id_wb_reg(in_b.wr), .id_is_mul(in_b.mul),
        .pc_en(pc_b), .id_en(id_b), .ex_flush(exf_b), .ex_hold(exh_b), .mem_flush(mf_b),
        .stall_count(cnt_b)
    );

    function automatic in_t ins(logic v, logic [4:0] a, logic ua, logic [4:0] b, logic ub,
                                logic we, logic [4:0] wr, logic mul);
        in_t t;
        t.rst = 1'b1; t.v = v; t.a = a; t.ua = ua; t.b = b; t.ub = ub;
        t.we = we; t.wr = wr; t.mul = mul;
        return t;
    endfunction

    function automatic in_t nop();
        return ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endfunction

    // Reset asserted while a valid instruction sits in ID
    function automatic in_t rstv();
        in_t t;
        t = ins(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1);
        t.rst = 1'b0;
        return t;
    endfunction

    function automatic exp_t ex(logic pc, logic exf, logic exh, logic [15:0] cnt);
        exp_t e;
        e.sel = 1'b0; e.id = 0;
        e.pc = pc; e.exf = exf; e.exh = exh; e.mf = exh; e.cnt = cnt;
        return e;
    endfunction

    function automatic exp_t exr();
        exp_t e;
        e = ex(1'b0, 1'b1, 1'b0, 16'd0);
        e.mf = 1'b1;
        return e;
    endfunction

    task automatic step(input bit sel, input in_t v, input exp_t e);
        @(posedge clk);
        #1;
        if (sel) in_b = v;
        else     in_a = v;
        e.sel = sel;
        e.id  = step_id;
        step_id++;
        q.push_back(e);
    endtask

    // Monitor: one expectation per cycle, compared at the falling edge
    initial begin
        exp_t e;
        logic [20:0] got, req;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.sel) got = {pc_b, id_b, exf_b, exh_b, mf_b, cnt_b};
                else       got = {pc_a, id_a, exf_a, exh_a, mf_a, 12'd0, cnt_a};
                req = {e.pc, e.pc, e.exf, e.exh, e.mf, e.cnt};
                n_checks++;
                if (got !== req) begin
                    n_fail++;
                    $display("FAIL %s step %0d: got pc/id/exf/exh/mf=%b%b%b%b%b cnt=%0d, want %b%b%b%b%b cnt=%0d",
                             e.sel ? "bypass" : "nobypass", e.id,
                             got[20], got[19], got[18], got[17], got[16], got[15:0],
                             req[20], req[19], req[18], req[17], req[16], req[15:0]);
                end
            end
        end
    end

    initial begin
        in_a = rstv();
        in_b = rstv();

        // ---------------- Instance A: no RF bypass, MUL_LAT=4, CNT_W=4 ----------------
        step(0, rstv(), exr());
        step(0, rstv(), exr());
        step(0, nop(), ex(1, 1, 0, 0));
        // RAW on r5: three stall cycles
        step(0, ins(1, 5'd1, 1, 5'd0, 0, 1, 5'd5, 0), ex(1, 0, 0, 0));
        step(0, ins(1, 5'd5, 1, 5'd0, 0, 1, 5'd6, 0), ex(0, 1, 0, 0));
        step(0, ins(1, 5'd5, 1, 5'd0, 0, 1, 5'd6, 0), ex(0, 1, 0, 1));
        step(0, ins(1, 5'd5, 1, 5'd0, 0, 1, 5'd6, 0), ex(0, 1, 0, 2));
        step(0, ins(1, 5'd5, 1, 5'd0, 0, 1, 5'd6, 0), ex(1, 0, 0, 3));
        for (int i = 0; i < 3; i++) step(0, nop(), ex(1, 1, 0, 3));
        // r0 never hazards; unused source B never hazards
        step(0, ins(1, 5'd1, 1, 5'd0, 0, 1, 5'd0, 0), ex(1, 0, 0, 3));
        step(0, ins(1, 5'd0, 1, 5'd0, 1, 1, 5'd5, 0), ex(1, 0, 0, 3));
        step(0, ins(1, 5'd1, 1, 5'd5, 0, 1, 5'd2, 0), ex(1, 0, 0, 3));
        for (int i = 0; i < 3; i++) step(0, nop(), ex(1, 1, 0, 3));
        // Both sources match different entries: wait for the younger (r4)
        step(0, ins(1, 5'd1, 1, 5'd0, 0, 1, 5'd3, 0), ex(1, 0, 0, 3));
        step(0, ins(1, 5'd1, 1, 5'd0, 0, 1, 5'd4, 0), ex(1, 0, 0, 3));
        step(0, ins(1, 5'd3, 1, 5'd4, 1, 1, 5'd9, 0), ex(0, 1, 0, 3));
        step(0, ins(1, 5'd3, 1, 5'd4, 1, 1, 5'd9, 0), ex(0, 1, 0, 4));
        step(0, ins(1, 5'd3, 1, 5'd4, 1, 1, 5'd9, 0), ex(0, 1, 0, 5));
        step(0, ins(1, 5'd3, 1, 5'd4, 1, 1, 5'd9, 0), ex(1, 0, 0, 6));
        for (int i = 0; i < 3; i++) step(0, nop(), ex(1, 1, 0, 6));
        // Same destination r8 written twice: stall until the second retires
        step(0, ins(1, 5'd1, 1, 5'd0, 0, 1, 5'd8, 0), ex(1, 0, 0, 6));
        step(0, ins(1, 5'd1, 1, 5'd0, 0, 1, 5'd8, 0), ex(1, 0, 0, 6));
        step(0, ins(1, 5'd8, 1, 5'd0, 0, 0, 5'd10, 0), ex(0, 1, 0, 6));
        step(0, ins(1, 5'd8, 1, 5'd0, 0, 0, 5'd10, 0), ex(0, 1, 0, 7));
        step(0, ins(1, 5'd8, 1, 5'd0, 0, 0, 5'd10, 0), ex(0, 1, 0, 8));
        step(0, ins(1, 5'd8, 1, 5'd0, 0, 0, 5'd10, 0), ex(1, 0, 0, 9));
        step(0, nop(), ex(1, 1, 0, 9));
        // Multiply r7: EX held 3 cycles, then a reader of r7 waits for WB
        step(0, ins(1, 5'd1, 1, 5'd0, 0, 1, 5'd7, 1), ex(1, 0, 0, 9));
        step(0, ins(1, 5'd1, 1, 5'd0, 0, 1, 5'd11, 0), ex(0, 0, 1, 9));
        step(0, ins(1, 5'd1, 1, 5'd0, 0, 1, 5'd11, 0), ex(0, 0, 1, 10));
        step(0, ins(1, 5'd1, 1, 5'd0, 0, 1, 5'd11, 0), ex(0, 0, 1, 11));
        step(0, ins(1, 5'd1, 1, 5'd0, 0, 1, 5'd11, 0), ex(1, 0, 0, 12));
        step(0, ins(1, 5'd7, 1, 5'd0, 0, 1, 5'd12, 0), ex(0, 1, 0, 12));
        step(0, ins(1, 5'd7, 1, 5'd0, 0, 1, 5'd12, 0), ex(0, 1, 0, 13));
        step(0, ins(1, 5'd7, 1, 5'd0, 0, 1, 5'd12, 0), ex(1, 0, 0, 14));
        // Drive the 4-bit counter into saturation
        step(0, ins(1, 5'd12, 1, 5'd0, 0, 1, 5'd13, 0), ex(0, 1, 0, 14));
        step(0, ins(1, 5'd12, 1, 5'd0, 0, 1, 5'd13, 0), ex(0, 1, 0, 15));
        step(0, ins(1, 5'd12, 1, 5'd0, 0, 1, 5'd13, 0), ex(0, 1, 0, 15));
        step(0, ins(1, 5'd12, 1, 5'd0, 0, 1, 5'd13, 0), ex(1, 0, 0, 15));
        step(0, ins(1, 5'd1, 1, 5'd0, 0, 1, 5'd14, 1), ex(1, 0, 0, 15));
        step(0, nop(), ex(0, 0, 1, 15));
        step(0, nop(), ex(0, 0, 1, 15));
        // Async reset mid-multiply, then no residual hold or hazard
        step(0, rstv(), exr());
        step(0, nop(), ex(1, 1, 0, 0));
        step(0, ins(1, 5'd14, 1, 5'd13, 1, 1, 5'd15, 0), ex(1, 0, 0, 0));
        step(0, nop(), ex(1, 1, 0, 0));

        // ---------------- Instance B: RF bypass, MUL_LAT=2 ----------------
        step(1, rstv(), exr());
        step(1, nop(), ex(1, 1, 0, 0));
        step(1, ins(1, 5'd1, 1, 5'd0, 0, 1, 5'd5, 0), ex(1, 0, 0, 0));
        step(1, ins(1, 5'd5, 1, 5'd0, 0, 1, 5'd6, 0), ex(0, 1, 0, 0));
        step(1, ins(1, 5'd5, 1, 5'd0, 0, 1, 5'd6, 0), ex(0, 1, 0, 1));
        step(1, ins(1, 5'd5, 1, 5'd0, 0, 1, 5'd6, 0), ex(1, 0, 0, 2));
        step(1, ins(1, 5'd1, 1, 5'd0, 0, 1, 5'd7, 1), ex(1, 0, 0, 2));
        step(1, nop(), ex(0, 0, 1, 2));
        step(1, ins(1, 5'd0, 0, 5'd7, 1, 1, 5'd9, 0), ex(0, 1, 0, 3));
        step(1, ins(1, 5'd0, 0, 5'd7, 1, 1, 5'd9, 0), ex(0, 1, 0, 4));
        step(1, ins(1, 5'd0, 0, 5'd7, 1, 1, 5'd9, 0), ex(1, 0, 0, 5));
        // Invalid ID slot naming an in-flight register: bubble, no stall
        step(1, ins(0, 5'd9, 1, 5'd0, 0, 1, 5'd9, 0), ex(1, 1, 0, 5));
        step(1, nop(), ex(1, 1, 0, 5));

        // Let the monitor drain the queue, bounded
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
